load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block that runs every load and store against the data memory through a request/acknowledge handshake.
- Stalls the pipeline while a request is outstanding.
- Produces the aligned, sign- or zero-extended read data that the write-back stage selects as its memory result.
- Detects misaligned and illegal accesses and reports a 4-bit cause in the same format the write-back stage consumes.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, data bus width. Fixed at 64; the byte-enable width is DATA_WIDTH/8.

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_mem_access  in  1  memory-stage instruction is a load or store.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  access size/sign: LB/SB 000, LH/SH 001, LW/SW 010, LD/SD 011, LBU 100, LHU 101, LWU 110.
- i_addr  in  ADDR_WIDTH  effective byte address.
- i_store_data  in  DATA_WIDTH  rs2 value.
- o_stall  out  1  freeze stages upstream of memory.
- o_read_data  out  DATA_WIDTH  formatted load data, to write-back.
- o_exc  out  1  access exception.
- o_cause  out  4  exception cause.
- o_dmem_req  out  1  request valid.
- o_dmem_we  out  1  request is a write.
- o_dmem_addr  out  ADDR_WIDTH  address with bits [2:0] forced to 0.
- o_dmem_wdata  out  DATA_WIDTH  lane-shifted store data.
- o_dmem_be  out  8  byte enables.
- i_dmem_ack  in  1  request completed; read data valid this cycle.
- i_dmem_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset values: state IDLE. All o_dmem_* outputs are 0, o_read_data is 0, o_stall is 0, o_exc is 0, o_cause is 0.
- Reset takes effect at any time, including mid-request: the request is dropped and an ack arriving later is ignored.
- Alignment and legality are combinational on the inputs:
  - Misaligned: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0.
  - Illegal: funct3 111 on a load; funct3[2]=1 on a store.
- Exception response (IDLE with i_mem_access and an illegal or misaligned access):
  - o_exc=1, no request issued, o_stall=0.
  - o_cause: 4 = load misaligned, 6 = store misaligned, 2 = illegal. Illegal takes priority over misaligned.
- FSM states:
  - IDLE: on i_mem_access with a legal, aligned access, register address, wdata, be, we and funct3, then go to REQ. o_stall=1 combinationally in this cycle.
  - REQ: o_dmem_req=1 and the address/data are held stable. o_stall=1.
    - On i_dmem_ack: capture the formatted rdata into o_read_data (on a store, o_read_data is left unchanged), then go to DONE.
  - DONE: o_stall=0 and o_read_data is valid. i_mem_access is ignored here, because the same instruction is still present. Unconditionally go to IDLE.
- Minimum latency is 3 cycles per access: IDLE, REQ with ack, DONE. Each cycle without ack in REQ adds one stall cycle. There is no timeout.
- i_dmem_ack outside REQ is ignored.
- Store formatting:
  - o_dmem_wdata = store data shifted left by 8·addr[2:0].
  - o_dmem_be = size mask (01, 03, 0F, FF) shifted left by addr[2:0].
  - o_dmem_be=0 on loads.
- Load formatting: shift rdata right by 8·addr[2:0], truncate to the access size, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) to 64 bits.

Optional Feature:
- Macro: LSU_STATS_EN.
- Defined:
  - Adds outputs o_load_cnt, o_store_cnt and o_stall_cnt, each 16 bits, saturating at FFFF and reset to 0.
  - The load and store counters increment on the REQ→DONE transition.
  - The stall counter increments every cycle o_stall=1.
  - These counters feed the end-of-test check alongside the branch counters.
- Undefined: the ports are absent and no counter logic is generated. Functional behaviour is otherwise identical.

Decomposition:
- Shared package lsu_pkg holds:
  - the state enum (IDLE, REQ, DONE);
  - funct3 constants;
  - cause constants (2, 4, 6);
  - the size-mask function.
- One combinational sub-module, load_formatter, does lane extraction and extension. Its inputs are rdata, addr[2:0] and funct3; its output is the 64-bit result.

Test Plan:
- LD at 0x1000, memory returns 0x1122334455667788, ack in the first REQ cycle → one cycle of o_dmem_req with o_dmem_addr 0x1000. o_read_data=0x1122334455667788 in DONE. o_stall high for exactly 2 cycles.
- LB at 0x1007, rdata 0x80xx_xxxx_xxxx_xxxx → o_read_data=0xFFFFFFFFFFFFFF80. The same access as LBU gives 0x0000000000000080.
- SH at 0x2002, data 0xBEEF, ack delayed 4 cycles → o_dmem_be=0x0C, o_dmem_wdata[31:16]=0xBEEF, request fields stable for 5 cycles, o_stall high for 6 cycles.
- LW at 0x3001 → o_exc=1, o_cause=4, no o_dmem_req, o_stall=0. SD at 0x3004 → o_cause=6. Load with funct3 111 → o_cause=2.
- Reset asserted in REQ, then an ack pulse after release → state IDLE, outputs 0, the ack is ignored and no read data is captured.
- LSU_STATS_EN defined: 3 loads and 2 stores with 1-cycle ack → o_load_cnt=3, o_store_cnt=2, o_stall_cnt=10.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 encodings,
// exception cause codes and the access-size byte-mask helper.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;
   localparam logic [2:0] F3_NA = 3'b111;

   localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
   localparam logic [3:0] CAUSE_LD_MISALIGN  = 4'd4;
   localparam logic [3:0] CAUSE_ST_MISALIGN  = 4'd6;

   // Byte mask for an access of 1, 2, 4 or 8 bytes (funct3[1:0]).
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      unique case (size)
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Load lane extraction: shifts the addressed bytes down, truncates to the
// access size and sign- or zero-extends to 64 bits.
module load_formatter
   import lsu_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [63:0] result
);

   logic [63:0] lane;

   assign lane = rdata >> {addr_lo, 3'b000};

   // funct3[2] selects zero extension (the U variants).
   always_comb begin
      result = lane;
      unique case (funct3[1:0])
         2'b00:   result = funct3[2] ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
         2'b01:   result = funct3[2] ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
         2'b10:   result = funct3[2] ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
         default: result = lane;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit with req/ack data-memory handshake and access
// exception detection. Optional statistics counters under `LSU_STATS_EN.
//
// state | meaning
// IDLE  | waiting for an access; faults reported combinationally, legal access latched
// REQ   | request on the bus, fields held stable until ack
// DONE  | read data valid, pipeline released, same instruction still present
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_arst_n,
   input  logic                  i_mem_access,
   input  logic                  i_we,
   input  logic [2:0]            i_funct3,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_store_data,
   output logic                  o_stall,
   output logic [DATA_WIDTH-1:0] o_read_data,
   output logic                  o_exc,
   output logic [3:0]            o_cause,
   output logic                  o_dmem_req,
   output logic                  o_dmem_we,
   output logic [ADDR_WIDTH-1:0] o_dmem_addr,
   output logic [DATA_WIDTH-1:0] o_dmem_wdata,
   output logic [7:0]            o_dmem_be,
`ifdef LSU_STATS_EN
   output logic [15:0]           o_load_cnt,
   output logic [15:0]           o_store_cnt,
   output logic [15:0]           o_stall_cnt,
`endif
   input  logic                  i_dmem_ack,
   input  logic [DATA_WIDTH-1:0] i_dmem_rdata
);

   lsu_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [7:0]            be_q;
   logic                  we_q;
   logic [2:0]            funct3_q;
   logic                  illegal, misaligned;
   logic                  issue, capture;
   logic [63:0]           fmt_data;

   always_comb begin
      illegal = i_we ? i_funct3[2] : (i_funct3 == F3_NA);
      unique case (i_funct3[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = i_addr[0];
         2'b10:   misaligned = |i_addr[1:0];
         default: misaligned = |i_addr[2:0];
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      o_stall = 1'b0;
      o_exc   = 1'b0;
      o_cause = 4'd0;
      issue   = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_mem_access) begin
               if (illegal || misaligned) begin
                  o_exc   = 1'b1;
                  o_cause = illegal ? CAUSE_ILLEGAL
                          : (i_we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN);
               end else begin
                  issue   = 1'b1;
                  o_stall = 1'b1;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            o_stall = 1'b1;
            if (i_dmem_ack) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= 8'h00;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
      end else if (issue) begin
         addr_q   <= i_addr;
         wdata_q  <= i_store_data << {i_addr[2:0], 3'b000};
         be_q     <= i_we ? (size_mask(i_funct3[1:0]) << i_addr[2:0]) : 8'h00;
         we_q     <= i_we;
         funct3_q <= i_funct3;
      end
   end

   load_formatter u_load_formatter (
      .rdata   (i_dmem_rdata),
      .addr_lo (addr_q[2:0]),
      .funct3  (funct3_q),
      .result  (fmt_data)
   );

   // Stores leave the previous load result in place.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n)              o_read_data <= '0;
      else if (capture && !we_q)  o_read_data <= fmt_data;
   end

   assign o_dmem_req   = (state_q == REQ);
   assign o_dmem_we    = we_q;
   assign o_dmem_addr  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
   assign o_dmem_wdata = wdata_q;
   assign o_dmem_be    = be_q;

`ifdef LSU_STATS_EN
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         o_load_cnt  <= 16'd0;
         o_store_cnt <= 16'd0;
         o_stall_cnt <= 16'd0;
      end else begin
         if (capture && !we_q && o_load_cnt != 16'hFFFF)  o_load_cnt  <= o_load_cnt + 16'd1;
         if (capture && we_q && o_store_cnt != 16'hFFFF)  o_store_cnt <= o_store_cnt + 16'd1;
         if (o_stall && o_stall_cnt != 16'hFFFF)          o_stall_cnt <= o_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-level
// reference model; statistics outputs are checked when LSU_STATS_EN is defined.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        mem_access, we_in, dmem_ack;
   logic [2:0]  funct3;
   logic [63:0] addr, store_data, dmem_rdata;
   logic        stall, exc, dmem_req, dmem_we;
   logic [3:0]  cause;
   logic [63:0] read_data, dmem_addr, dmem_wdata;
   logic [7:0]  dmem_be;
`ifdef LSU_STATS_EN
   logic [15:0] load_cnt, store_cnt, stall_cnt;
`endif

   int          n_checks = 0;
   int          n_fail = 0;
   logic [63:0] exp_rd = 64'd0;
   int          exp_loads = 0, exp_stores = 0, exp_stalls = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .i_clk        (clk),
      .i_arst_n     (arst_n),
      .i_mem_access (mem_access),
      .i_we         (we_in),
      .i_funct3     (funct3),
      .i_addr       (addr),
      .i_store_data (store_data),
      .o_stall      (stall),
      .o_read_data  (read_data),
      .o_exc        (exc),
      .o_cause      (cause),
      .o_dmem_req   (dmem_req),
      .o_dmem_we    (dmem_we),
      .o_dmem_addr  (dmem_addr),
      .o_dmem_wdata (dmem_wdata),
      .o_dmem_be    (dmem_be),
`ifdef LSU_STATS_EN
      .o_load_cnt   (load_cnt),
      .o_store_cnt  (store_cnt),
      .o_stall_cnt  (stall_cnt),
`endif
      .i_dmem_ack   (dmem_ack),
      .i_dmem_rdata (dmem_rdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference load result: pick bytes arithmetically, then extend.
   function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                              input logic [2:0] f3);
      int          nb;
      logic [63:0] v, m;
      nb = 1 << f3[1:0];
      v  = rdata >> (8 * off);
      if (nb == 8) return v;
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (!f3[2] && v[8*nb-1]) v = v | ~m;
      return v;
   endfunction

   task automatic do_access(input logic we, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] sdata, input logic [63:0] rdata, input int delay);
      int          nb, off;
      logic        ill, mis;
      logic [63:0] exp_be, exp_wd;
      nb     = 1 << f3[1:0];
      off    = int'(a[2:0]);
      ill    = we ? (f3 >= 3'd4) : (f3 == 3'd7);
      mis    = (off % nb) != 0;
      exp_be = we ? ((((64'd1 << nb) - 64'd1) << off) & 64'hFF) : 64'd0;
      exp_wd = sdata << (8 * off);

      @(posedge clk); #1;
      mem_access = 1'b1; we_in = we; funct3 = f3; addr = a; store_data = sdata; dmem_ack = 1'b0;
      @(negedge clk);
      if (ill || mis) begin
         check("exc", exc, 1);
         check("cause", cause, ill ? 2 : (we ? 6 : 4));
         check("stall_exc", stall, 0);
         check("req_exc", dmem_req, 0);
         @(posedge clk); #1;
         mem_access = 1'b0;
         @(negedge clk);
         check("req_after_exc", dmem_req, 0);
         return;
      end
      check("exc_ok", exc, 0);
      check("stall_idle", stall, 1);
      check("req_idle", dmem_req, 0);
      exp_stalls += 1;
      for (int k = 0; k <= delay; k++) begin
         @(posedge clk); #1;
         dmem_ack   = (k == delay);
         dmem_rdata = (k == delay) ? rdata : {$urandom, $urandom};
         @(negedge clk);
         check("req", dmem_req, 1);
         check("stall_req", stall, 1);
         check("dmem_addr", dmem_addr, {a[63:3], 3'b000});
         check("dmem_we", dmem_we, we);
         check("dmem_be", dmem_be, exp_be);
         if (we) check("dmem_wdata", dmem_wdata, exp_wd);
         exp_stalls += 1;
      end
      @(posedge clk); #1;
      dmem_ack   = 1'b0;
      dmem_rdata = {$urandom, $urandom};
      if (!we) exp_rd = model_load(rdata, off, f3);
      if (we) exp_stores++; else exp_loads++;
      @(negedge clk);
      check("stall_done", stall, 0);
      check("req_done", dmem_req, 0);
      check("exc_done", exc, 0);
      check("read_data", read_data, exp_rd);
      @(posedge clk); #1;
      mem_access = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r_we;
      logic [2:0]  r_f3, r_off;
      logic [63:0] r_addr;
      int          nb;

      arst_n = 1'b0; mem_access = 1'b0; we_in = 1'b0; funct3 = 3'b000;
      addr = 64'd0; store_data = 64'd0; dmem_ack = 1'b0; dmem_rdata = 64'd0;
      #12;
      check("rst_stall", stall, 0);
      check("rst_req", dmem_req, 0);
      check("rst_rd", read_data, 0);
      check("rst_addr", dmem_addr, 0);
      check("rst_be", dmem_be, 0);
      @(posedge clk); #1;
      arst_n = 1'b1;

      // Directed cases
      do_access(1'b0, 3'b011, 64'h1000, 64'd0, 64'h1122334455667788, 0);
      check("ld_value", read_data, 64'h1122334455667788);
      do_access(1'b0, 3'b000, 64'h1007, 64'd0, 64'h80AB_CDEF_0123_4567, 1);
      check("lb_sext", read_data, 64'hFFFF_FFFF_FFFF_FF80);
      do_access(1'b0, 3'b100, 64'h1007, 64'd0, 64'h80AB_CDEF_0123_4567, 0);
      check("lbu_zext", read_data, 64'h0000_0000_0000_0080);
      do_access(1'b1, 3'b001, 64'h2002, 64'hBEEF, 64'd0, 4);
      check("sh_keeps_rd", read_data, 64'h80);
      do_access(1'b0, 3'b010, 64'h3001, 64'd0, 64'd0, 0);
      do_access(1'b1, 3'b011, 64'h3004, 64'd0, 64'd0, 0);
      do_access(1'b0, 3'b111, 64'h3000, 64'd0, 64'd0, 0);

      // A misaligned address without i_mem_access must not raise an exception
      @(posedge clk); #1;
      addr = 64'h3001; funct3 = 3'b010; we_in = 1'b0; mem_access = 1'b0;
      @(negedge clk);
      check("no_access_exc", exc, 0);

      // Reset mid-request, then a stray ack
      @(posedge clk); #1;
      mem_access = 1'b1; we_in = 1'b0; funct3 = 3'b011; addr = 64'h4000;
      @(posedge clk); #1;
      arst_n = 1'b0; mem_access = 1'b0;
      exp_rd = 64'd0; exp_loads = 0; exp_stores = 0; exp_stalls = 0;
      #1;
      check("rst_mid_req", dmem_req, 0);
      check("rst_mid_stall", stall, 0);
      check("rst_mid_rd", read_data, 0);
      check("rst_mid_addr", dmem_addr, 0);
      @(posedge clk); #1;
      arst_n = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      check("stray_ack_req", dmem_req, 0);
      check("stray_ack_stall", stall, 0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      check("stray_ack_rd", read_data, 0);

      // Randomized accesses
      for (int i = 0; i < 200; i++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_f3   = 3'($urandom_range(0, 7));
         r_addr = {$urandom, $urandom};
         nb     = 1 << r_f3[1:0];
         if ($urandom_range(0, 3) != 0) begin
            r_off  = 3'($urandom_range(0, 7)) & ~3'(nb - 1);
            r_addr[2:0] = r_off;
         end
         do_access(r_we, r_f3, r_addr, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3));
      end

`ifdef LSU_STATS_EN
      @(negedge clk);
      check("load_cnt", 64'(load_cnt), 64'(exp_loads));
      check("store_cnt", 64'(store_cnt), 64'(exp_stores));
      check("stall_cnt", 64'(stall_cnt), 64'(exp_stalls));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
